// File: rtl/odd_matrix_ind_tx.sv
// odd_matrix_ind_tx
// Stream source for the odd-cell matrix block. A host first fills a buffer
// with [row, col] index pairs. Pairs outside the configured matrix are
// consumed but dropped, and they raise err. On start the buffer is replayed
// as an AXI-stream-style index stream, with m/n held for the consumer. The
// block then captures the consumer's odd-cell count. It is one-shot: once a
// result is captured, only rst begins a new run.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   cfg_m, cfg_n        matrix dimensions (range check, latched at start)
//   wr_data/valid/ready host write channel, [0]=row, [1]=col
//   start               begin transmission (honoured in IDLE only)
//   busy                high while sending or waiting for the result
//   m, n                dimensions latched at start
//   ind_tdata/tvalid/tlast/tready  index stream to the consumer
//   res_data, res_tvalid           consumer result (level valid)
//   result, done        captured count and completion flag
//   err                 sticky error: bad index write or empty start
module odd_matrix_ind_tx #(
  parameter int MAX_IND_LEN = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      cfg_m,
  input  logic [7:0]      cfg_n,
  input  logic [1:0][7:0] wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic            start,
  output logic            busy,
  output logic [7:0]      m,
  output logic [7:0]      n,
  output logic [1:0][7:0] ind_tdata,
  output logic            ind_tvalid,
  output logic            ind_tlast,
  input  logic            ind_tready,
  input  logic [7:0]      res_data,
  input  logic            res_tvalid,
  output logic [7:0]      result,
  output logic            done,
  output logic            err
);

  localparam int CW = $clog2(MAX_IND_LEN + 1);
  localparam int IW = (MAX_IND_LEN > 1) ? $clog2(MAX_IND_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RES,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rd_ptr;
  logic [CW-1:0]   nxt_ptr;
  logic [1:0][7:0] pair_buf [MAX_IND_LEN];

  logic wr_fire;
  logic wr_in_range;
  logic start_go;
  logic start_empty;
  logic beat_fire;

  // A start request blocks writes in the same cycle. This keeps the latched
  // count consistent with what is actually sent.
  assign wr_ready    = !rst && (state == IDLE) && (cnt < CW'(MAX_IND_LEN)) && !start;
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = (wr_data[0] < cfg_m) && (wr_data[1] < cfg_n);
  assign start_go    = (state == IDLE) && start && (cnt != '0);
  assign start_empty = (state == IDLE) && start && (cnt == '0);
  assign beat_fire   = (state == SEND) && ind_tvalid && ind_tready;
  assign nxt_ptr     = rd_ptr + CW'(1);

  assign busy = (state == SEND) || (state == WAIT_RES);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_go) state_nxt = SEND;
      SEND:     if (beat_fire && ind_tlast) state_nxt = WAIT_RES;
      WAIT_RES: if (res_tvalid) state_nxt = DONE;
      DONE:     state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  // The pair storage has no reset. Reset empties it logically by clearing
  // cnt, so stale entries are never read back.
  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) begin
      pair_buf[cnt[IW-1:0]] <= wr_data;
    end
  end

  // Stream outputs are registered. The next pair is preloaded on each
  // handshake, so tdata/tlast stay untouched while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rd_ptr     <= '0;
      m          <= '0;
      n          <= '0;
      result     <= '0;
      err        <= 1'b0;
      ind_tvalid <= 1'b0;
      ind_tlast  <= 1'b0;
      ind_tdata  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_in_range) begin
          cnt <= cnt + CW'(1);
        end else begin
          err <= 1'b1;
        end
      end

      if (start_empty) begin
        err <= 1'b1;
      end

      if (start_go) begin
        m          <= cfg_m;
        n          <= cfg_n;
        rd_ptr     <= '0;
        ind_tvalid <= 1'b1;
        ind_tdata  <= pair_buf[0];
        ind_tlast  <= (cnt == CW'(1));
      end

      if (beat_fire) begin
        rd_ptr <= nxt_ptr;
        if (ind_tlast) begin
          ind_tvalid <= 1'b0;
          ind_tlast  <= 1'b0;
        end else begin
          ind_tdata <= pair_buf[nxt_ptr[IW-1:0]];
          ind_tlast <= (nxt_ptr == cnt - CW'(1));
        end
      end

      if ((state == WAIT_RES) && res_tvalid) begin
        result <= res_data;
      end
    end
  end

endmodule

// File: tb/tb_odd_matrix_ind_tx.sv
// Testbench for odd_matrix_ind_tx with a 4-entry buffer.
// A queue of expected beats and an expected error flag are derived from the
// host writes using plain range rules. Every stream handshake is compared
// against that queue.
module tb_odd_matrix_ind_tx;

  localparam int MAX_LEN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      cfg_m, cfg_n;
  logic [1:0][7:0] wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic            start;
  logic            busy;
  logic [7:0]      m, n;
  logic [1:0][7:0] ind_tdata;
  logic            ind_tvalid, ind_tlast, ind_tready;
  logic [7:0]      res_data;
  logic            res_tvalid;
  logic [7:0]      result;
  logic            done, err;

  always #5 clk = ~clk;

  odd_matrix_ind_tx #(.MAX_IND_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .cfg_m(cfg_m), .cfg_n(cfg_n),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .start(start), .busy(busy), .m(m), .n(n),
    .ind_tdata(ind_tdata), .ind_tvalid(ind_tvalid), .ind_tlast(ind_tlast),
    .ind_tready(ind_tready), .res_data(res_data), .res_tvalid(res_tvalid),
    .result(result), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  bit exp_err;

  typedef struct {
    logic [7:0] cm;
    logic [7:0] cn;
    logic [7:0] row;
    logic [7:0] col;
    bit         store;
    bit         err_after;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Host write; the expected acceptance/storage comes from the model rules.
  task automatic applyStimulus(input logic [7:0] row, input logic [7:0] col);
    bit exp_rdy;
    exp_rdy = (exp_q.size() < MAX_LEN);
    wr_data[0] = row;
    wr_data[1] = col;
    wr_valid   = 1'b1;
    #1;
    checkOutput("wr_ready", wr_ready, exp_rdy);
    if (exp_rdy) begin
      if (row < cfg_m && col < cfg_n) exp_q.push_back({col, row});
      else exp_err = 1'b1;
    end
    tick();
    wr_valid = 1'b0;
    checkOutput("err_after_write", err, exp_err);
  endtask

  task automatic reset_dut(input bit do_checks);
    rst        = 1'b1;
    wr_valid   = 1'b0;
    start      = 1'b0;
    ind_tready = 1'b0;
    res_tvalid = 1'b0;
    tick();
    if (do_checks) begin
      checkOutput("rst_wr_ready", wr_ready, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_tvalid", ind_tvalid, 0);
      checkOutput("rst_tlast", ind_tlast, 0);
      checkOutput("rst_tdata", ind_tdata, 0);
      checkOutput("rst_m", m, 0);
      checkOutput("rst_n", n, 0);
      checkOutput("rst_result", result, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
    end
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    #1;
    if (do_checks) checkOutput("post_rst_wr_ready", wr_ready, 1);
  endtask

  task automatic start_run();
    start = 1'b1;
    #1;
    checkOutput("wr_ready_during_start", wr_ready, 0);
    tick();
    start = 1'b0;
    #1;
  endtask

  // Drains the stream with a chosen ready pattern (0: always, 1: 1,0,0,1, 2: random).
  task automatic send_and_check(input int mode, input logic [7:0] em, input logic [7:0] en);
    int beats = 0;
    int cyc = 0;
    bit got_last = 1'b0;
    bit stalled = 1'b0;
    logic [15:0] held;
    logic held_last;
    held = '0;
    held_last = 1'b0;
    while (!got_last && cyc < 200) begin
      case (mode)
        0:       ind_tready = 1'b1;
        1:       ind_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ind_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      checkOutput("tvalid_mid_list", ind_tvalid, 1);
      checkOutput("m_held", m, em);
      checkOutput("n_held", n, en);
      if (stalled) begin
        checkOutput("stall_tdata", ind_tdata, held);
        checkOutput("stall_tlast", ind_tlast, held_last);
      end
      if (ind_tvalid && ind_tready) begin
        if (beats >= exp_q.size()) begin
          checks++;
          errors++;
          $display("[TB] FAIL beat_overrun: got beat %0d required %0d beats", beats + 1, exp_q.size());
          got_last = 1'b1;
        end else begin
          checkOutput("beat_data", ind_tdata, exp_q[beats]);
          checkOutput("beat_last", ind_tlast, 16'(beats == exp_q.size() - 1));
          if (ind_tlast) got_last = 1'b1;
        end
        beats++;
        stalled = 1'b0;
      end else begin
        stalled   = ind_tvalid;
        held      = ind_tdata;
        held_last = ind_tlast;
      end
      tick();
      cyc++;
    end
    if (!got_last) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: got no tlast after %0d cycles, required within 200", cyc);
    end
    checkOutput("beat_count", 16'(beats), 16'(exp_q.size()));
    checkOutput("tvalid_after_last", ind_tvalid, 0);
    checkOutput("busy_wait_res", busy, 1);
    checkOutput("err_during_run", err, exp_err);
    ind_tready = 1'b0;
  endtask

  task automatic finish_run(input logic [7:0] res);
    res_data   = res;
    res_tvalid = 1'b1;
    #1;
    checkOutput("done_before_res", done, 0);
    tick();
    res_tvalid = 1'b0;
    #1;
    checkOutput("result", result, res);
    checkOutput("done", done, 1);
    checkOutput("busy_after_res", busy, 0);
  endtask

  initial begin
    logic [7:0] em, en;
    rst = 1'b1; cfg_m = '0; cfg_n = '0; wr_data = '0; wr_valid = 1'b0;
    start = 1'b0; ind_tready = 1'b0; res_data = '0; res_tvalid = 1'b0;
    exp_err = 1'b0;

    tbl[0] = '{8'd1,   8'd1,   8'd0,   8'd0,   1'b1, 1'b0};
    tbl[1] = '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0, 1'b1};
    tbl[2] = '{8'd1,   8'd1,   8'd0,   8'd1,   1'b0, 1'b1};
    tbl[3] = '{8'd255, 8'd255, 8'd254, 8'd254, 1'b1, 1'b1};
    tbl[4] = '{8'd255, 8'd255, 8'd255, 8'd0,   1'b0, 1'b1};
    tbl[5] = '{8'd8,   8'd4,   8'd7,   8'd3,   1'b1, 1'b1};
    tbl[6] = '{8'd8,   8'd4,   8'd0,   8'd4,   1'b0, 1'b1};
    tbl[7] = '{8'd4,   8'd3,   8'd3,   8'd2,   1'b1, 1'b1};

    tick();
    reset_dut(1'b1);

    // Table-driven range checks; the four stored entries fill the buffer.
    for (int i = 0; i < 8; i++) begin
      cfg_m = tbl[i].cm;
      cfg_n = tbl[i].cn;
      wr_data[0] = tbl[i].row;
      wr_data[1] = tbl[i].col;
      wr_valid = 1'b1;
      #1;
      checkOutput($sformatf("tbl_wr_ready_%0d", i), wr_ready, 1);
      tick();
      wr_valid = 1'b0;
      checkOutput($sformatf("tbl_err_%0d", i), err, tbl[i].err_after);
      if (tbl[i].store) exp_q.push_back({tbl[i].col, tbl[i].row});
    end
    exp_err = 1'b1;
    checkOutput("tbl_full_wr_ready", wr_ready, 0);
    cfg_m = 8'd9; cfg_n = 8'd9;
    start_run();
    checkOutput("tbl_first_tdata", ind_tdata, 16'h0000);
    send_and_check(0, 8'd9, 8'd9);
    finish_run(8'h5A);
    start = 1'b1; wr_valid = 1'b1;
    tick();
    start = 1'b0; wr_valid = 1'b0;
    checkOutput("done_terminal", done, 1);
    checkOutput("done_no_tvalid", ind_tvalid, 0);
    checkOutput("done_wr_ready", wr_ready, 0);

    // Basic run
    reset_dut(1'b0);
    cfg_m = 8'd2; cfg_n = 8'd3;
    applyStimulus(8'd0, 8'd1);
    applyStimulus(8'd1, 8'd1);
    start_run();
    checkOutput("basic_first_tdata", ind_tdata, 16'h0100);
    checkOutput("basic_first_tlast", ind_tlast, 0);
    send_and_check(0, 8'd2, 8'd3);
    finish_run(8'd6);

    // Backpressure with ready 1,0,0,1
    reset_dut(1'b0);
    cfg_m = 8'd2; cfg_n = 8'd2;
    applyStimulus(8'd1, 8'd1);
    applyStimulus(8'd0, 8'd0);
    start_run();
    send_and_check(1, 8'd2, 8'd2);
    finish_run(8'd0);

    // Empty start sets err and stays idle; later writes and sends still work
    reset_dut(1'b0);
    start_run();
    checkOutput("empty_err", err, 1);
    checkOutput("empty_tvalid", ind_tvalid, 0);
    checkOutput("empty_busy", busy, 0);
    checkOutput("empty_wr_ready", wr_ready, 1);
    exp_err = 1'b1;
    cfg_m = 8'd5; cfg_n = 8'd5;
    applyStimulus(8'd4, 8'd4);
    start_run();
    send_and_check(0, 8'd5, 8'd5);
    finish_run(8'd1);

    // Full buffer: five back-to-back writes, the fifth is refused
    reset_dut(1'b0);
    cfg_m = 8'd8; cfg_n = 8'd8;
    for (int i = 0; i < 5; i++) applyStimulus(8'(i), 8'(7 - i));
    checkOutput("full_wr_ready", wr_ready, 0);
    start_run();
    send_and_check(0, 8'd8, 8'd8);
    finish_run(8'd12);

    // Range check: (2,0) is rejected with err, then (1,0) is the only beat
    reset_dut(1'b0);
    cfg_m = 8'd2; cfg_n = 8'd2;
    applyStimulus(8'd2, 8'd0);
    applyStimulus(8'd1, 8'd0);
    start_run();
    checkOutput("range_tdata", ind_tdata, 16'h0001);
    checkOutput("range_tlast", ind_tlast, 1);
    send_and_check(0, 8'd2, 8'd2);
    finish_run(8'd2);

    // An invalid write in the start cycle is neither accepted nor flagged
    reset_dut(1'b0);
    cfg_m = 8'd2; cfg_n = 8'd2;
    applyStimulus(8'd1, 8'd1);
    wr_data[0] = 8'd5; wr_data[1] = 8'd5; wr_valid = 1'b1;
    start_run();
    wr_valid = 1'b0;
    checkOutput("start_write_err", err, 0);
    send_and_check(0, 8'd2, 8'd2);
    finish_run(8'd3);

    // Reset in the middle of a stalled send
    reset_dut(1'b0);
    cfg_m = 8'd3; cfg_n = 8'd3;
    applyStimulus(8'd0, 8'd0);
    applyStimulus(8'd1, 8'd2);
    applyStimulus(8'd2, 8'd1);
    start_run();
    tick();
    tick();
    checkOutput("stalled_tvalid", ind_tvalid, 1);
    checkOutput("stalled_m", m, 3);
    reset_dut(1'b1);
    cfg_m = 8'd3; cfg_n = 8'd3;
    applyStimulus(8'd2, 8'd2);
    start_run();
    send_and_check(0, 8'd3, 8'd3);
    finish_run(8'd9);

    // Randomized runs against the queue model
    for (int it = 0; it < 20; it++) begin
      reset_dut(1'b0);
      cfg_m = 8'($urandom_range(1, 8));
      cfg_n = 8'($urandom_range(1, 8));
      for (int k = 0, lim = $urandom_range(0, 6); k < lim; k++) begin
        if ($urandom_range(0, 3) == 0) tick();
        else applyStimulus(8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)));
      end
      em = cfg_m;
      en = cfg_n;
      start_run();
      if (exp_q.size() == 0) begin
        exp_err = 1'b1;
        checkOutput("rnd_empty_err", err, 1);
        checkOutput("rnd_empty_tvalid", ind_tvalid, 0);
      end else begin
        cfg_m = 8'($urandom);
        cfg_n = 8'($urandom);
        send_and_check(2, em, en);
        finish_run(8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
